// File: rtl/reg_file_scoreboard_pkg.sv
// Shared defaults for the decode-side register file with its pending-write scoreboard.
// Imported by the top and by the bypassing read port.
package reg_file_scoreboard_pkg;

    localparam int DEF_REG_FILE_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH     = 5;
    localparam int DEF_NUM_REGS       = 32;

    typedef logic [DEF_REG_FILE_WIDTH-1:0] word_t;
    typedef logic [DEF_ADDR_WIDTH-1:0]     reg_addr_t;

endpackage

// File: rtl/reg_file_scoreboard_read.sv
// One decode read port: r0 masking, same-cycle write-back bypass and source hazard.
// pend is already qualified by the port's use flag.
module reg_bypass_read
    import reg_file_scoreboard_pkg::*;
#(
    parameter int REG_FILE_WIDTH = DEF_REG_FILE_WIDTH,
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH
) (
    input  logic [ADDR_WIDTH-1:0]     addr,
    input  logic                      used,
    input  logic                      busy_bit,
    input  logic [REG_FILE_WIDTH-1:0] reg_value,
    input  logic                      wb_en,
    input  logic [ADDR_WIDTH-1:0]     wb_addr,
    input  logic [REG_FILE_WIDTH-1:0] wb_data,
    output logic [REG_FILE_WIDTH-1:0] data,
    output logic                      pend
);

    logic addr_is_zero;
    logic wb_hit;

    assign addr_is_zero = (addr == '0);
    assign wb_hit       = wb_en && (wb_addr == addr);

    // A write landing this cycle both supplies the value and resolves the hazard.
    always_comb begin
        if (addr_is_zero) begin
            data = '0;
        end else if (wb_hit) begin
            data = wb_data;
        end else begin
            data = reg_value;
        end
    end

    assign pend = used && busy_bit && !wb_hit && !addr_is_zero;

endmodule

// File: rtl/reg_file_scoreboard.sv
// Register file fed by write-back, with two bypassing decode read ports and a
// per-register busy scoreboard that drives the decode stall.
module reg_file_scoreboard
    import reg_file_scoreboard_pkg::*;
#(
    parameter int REG_FILE_WIDTH = DEF_REG_FILE_WIDTH,
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int NUM_REGS       = DEF_NUM_REGS
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      RegW_EN,
    input  logic [ADDR_WIDTH-1:0]     addrD,
    input  logic [REG_FILE_WIDTH-1:0] WriteData,
    input  logic [ADDR_WIDTH-1:0]     addrA,
    input  logic [ADDR_WIDTH-1:0]     addrB,
    input  logic                      useA,
    input  logic                      useB,
    input  logic                      issue_valid,
    input  logic                      issue_RegW_EN,
    input  logic [ADDR_WIDTH-1:0]     issue_addrD,
    output logic [REG_FILE_WIDTH-1:0] readA,
    output logic [REG_FILE_WIDTH-1:0] readB,
    output logic                      stall,
    output logic [NUM_REGS-1:0]       busy
);

    if (NUM_REGS != (1 << ADDR_WIDTH)) begin : g_param_check
        $error("reg_file_scoreboard: NUM_REGS must equal 2**ADDR_WIDTH");
    end

    logic [REG_FILE_WIDTH-1:0] regs [NUM_REGS];
    logic [NUM_REGS-1:0]       busy_next;
    logic                      wb_fire;
    logic                      issue_fire;
    logic                      pend_a;
    logic                      pend_b;

    assign wb_fire    = RegW_EN && (addrD != '0);
    assign issue_fire = issue_valid && !stall && issue_RegW_EN && (issue_addrD != '0);

    // NOTE: the array is reset element by element because a reset must leave
    // every architectural register reading zero; this rules out a RAM macro.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_fire) begin
            // NOTE: non-blocking assignment so every flop samples pre-edge values.
            regs[addrD] <= WriteData;
        end
    end

    // Clear is applied first so a same-cycle issue to that register wins.
    always_comb begin
        // NOTE: default copy first keeps this block free of inferred latches.
        busy_next = busy;
        if (wb_fire) begin
            busy_next[addrD] = 1'b0;
        end
        if (issue_fire) begin
            busy_next[issue_addrD] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    reg_bypass_read #(
        .REG_FILE_WIDTH (REG_FILE_WIDTH),
        .ADDR_WIDTH     (ADDR_WIDTH)
    ) u_read_a (
        .addr      (addrA),
        .used      (useA),
        .busy_bit  (busy[addrA]),
        .reg_value (regs[addrA]),
        .wb_en     (RegW_EN),
        .wb_addr   (addrD),
        .wb_data   (WriteData),
        .data      (readA),
        .pend      (pend_a)
    );

    reg_bypass_read #(
        .REG_FILE_WIDTH (REG_FILE_WIDTH),
        .ADDR_WIDTH     (ADDR_WIDTH)
    ) u_read_b (
        .addr      (addrB),
        .used      (useB),
        .busy_bit  (busy[addrB]),
        .reg_value (regs[addrB]),
        .wb_en     (RegW_EN),
        .wb_addr   (addrD),
        .wb_data   (WriteData),
        .data      (readB),
        .pend      (pend_b)
    );

    assign stall = pend_a || pend_b;

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Directed bench: stimulus pushes hand-computed expectations into a queue and a
// negedge monitor pops and compares them against the DUT outputs.
module tb_reg_file_scoreboard;

    localparam int W  = 32;
    localparam int AW = 5;
    localparam int NR = 32;

    localparam bit [3:0] M_A    = 4'b0001;
    localparam bit [3:0] M_B    = 4'b0010;
    localparam bit [3:0] M_S    = 4'b0100;
    localparam bit [3:0] M_BUSY = 4'b1000;
    localparam bit [3:0] M_ALL  = 4'b1111;

    typedef struct {
        string          name;
        bit [3:0]       mask;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic           s;
        logic [NR-1:0]  bsy;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          RegW_EN;
    logic [AW-1:0] addrD;
    logic [W-1:0]  WriteData;
    logic [AW-1:0] addrA;
    logic [AW-1:0] addrB;
    logic          useA;
    logic          useB;
    logic          issue_valid;
    logic          issue_RegW_EN;
    logic [AW-1:0] issue_addrD;
    logic [W-1:0]  readA;
    logic [W-1:0]  readB;
    logic          stall;
    logic [NR-1:0] busy;

    exp_t exp_q[$];
    logic chk_en = 1'b0;
    int   total  = 0;
    int   bad    = 0;

    always #5 clk = ~clk;

    reg_file_scoreboard dut (
        .clk           (clk),
        .reset         (reset),
        .RegW_EN       (RegW_EN),
        .addrD         (addrD),
        .WriteData     (WriteData),
        .addrA         (addrA),
        .addrB         (addrB),
        .useA          (useA),
        .useB          (useB),
        .issue_valid   (issue_valid),
        .issue_RegW_EN (issue_RegW_EN),
        .issue_addrD   (issue_addrD),
        .readA         (readA),
        .readB         (readB),
        .stall         (stall),
        .busy          (busy)
    );

    task automatic check(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: compares whenever the stimulus presents a cycle for checking.
    always @(negedge clk) begin
        if (chk_en) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL scoreboard_underflow: got empty queue expected an entry");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if ((e.mask & M_A) != 0)    check({e.name, ".readA"}, readA, e.a);
                if ((e.mask & M_B) != 0)    check({e.name, ".readB"}, readB, e.b);
                if ((e.mask & M_S) != 0)    check({e.name, ".stall"}, {31'd0, stall}, {31'd0, e.s});
                if ((e.mask & M_BUSY) != 0) check({e.name, ".busy"}, busy, e.bsy);
            end
        end
    end

    task automatic idle();
        RegW_EN = 0; addrD = '0; WriteData = '0;
        addrA = '0; addrB = '0; useA = 0; useB = 0;
        issue_valid = 0; issue_RegW_EN = 0; issue_addrD = '0;
    endtask

    task automatic expect_now(input string name, input bit [3:0] mask, input logic [W-1:0] a,
                              input logic [W-1:0] b, input logic s, input logic [NR-1:0] bsy);
        exp_t e;
        e.name = name; e.mask = mask; e.a = a; e.b = b; e.s = s; e.bsy = bsy;
        exp_q.push_back(e);
        chk_en = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        chk_en = 1'b0;
        idle();
    endtask

    task automatic issue(input logic [AW-1:0] d);
        issue_valid = 1; issue_RegW_EN = 1; issue_addrD = d;
    endtask

    task automatic wb(input logic [AW-1:0] d, input logic [W-1:0] v);
        RegW_EN = 1; addrD = d; WriteData = v;
    endtask

    initial begin
        idle();
        reset = 1;
        tick(); tick();
        reset = 0;

        // 1: post-reset reads, r0 write ignored
        for (int r = 1; r < NR; r++) begin
            addrA = AW'(r); addrB = AW'(NR - r); useA = 1; useB = 1;
            expect_now("reset_read", M_ALL, 0, 0, 0, 0);
            tick();
        end
        wb(0, 32'hDEAD); addrA = 0; addrB = 0;
        expect_now("r0_write_cycle", M_A | M_B, 0, 0, 0, 0);
        tick();
        addrA = 0; useA = 1;
        expect_now("r0_after", M_ALL, 0, 0, 0, 0);
        tick();

        // 2: bypass then stored value
        wb(5, 32'h1234); addrA = 5; addrB = 5;
        expect_now("bypass", M_A | M_B, 32'h1234, 32'h1234, 0, 0);
        tick();
        addrA = 5;
        expect_now("stored", M_A | M_BUSY, 32'h1234, 0, 0, 0);
        tick();

        // 3: RAW hazard on r7 resolved by WB bypass
        issue(7);
        expect_now("issue7", M_S | M_BUSY, 0, 0, 0, 0);
        tick();
        useA = 1; addrA = 7;
        expect_now("stall7", M_A | M_S | M_BUSY, 0, 0, 1, 32'h80);
        tick();
        useA = 1; addrA = 7; wb(7, 32'h55);
        expect_now("wb7", M_A | M_S | M_BUSY, 32'h55, 0, 0, 32'h80);
        tick();
        useA = 1; addrA = 7;
        expect_now("after7", M_ALL, 32'h55, 0, 0, 0);
        tick();

        // 4: set wins over clear on r3
        issue(3);
        tick();
        issue(3); wb(3, 32'h33);
        expect_now("setclr3", M_BUSY, 0, 0, 0, 32'h8);
        tick();
        addrA = 3;
        expect_now("setwins3", M_A | M_BUSY, 32'h33, 0, 0, 32'h8);
        tick();
        wb(3, 32'h34);
        tick();
        useB = 1; addrB = 3;
        expect_now("clear3", M_B | M_S | M_BUSY, 0, 32'h34, 0, 0);
        tick();

        // 5: stalled issue is ignored; unused source doesn't stall; r0 never busy
        issue(8);
        tick();
        useB = 1; addrB = 8; issue(9);
        expect_now("stall_issue9", M_S | M_BUSY, 0, 0, 1, 32'h100);
        tick();
        useA = 0; addrA = 8;
        expect_now("no_set9", M_S | M_BUSY, 0, 0, 0, 32'h100);
        tick();
        wb(8, 32'h88);
        tick();
        issue(0);
        tick();
        useA = 1; addrA = 0;
        expect_now("r0_issue", M_S | M_BUSY, 0, 0, 0, 0);
        tick();

        // 6: reset discards pending state and the concurrent WB write
        issue(4); wb(4, 32'h77);
        tick();
        addrA = 4;
        expect_now("pre_reset4", M_A | M_BUSY, 32'h77, 0, 0, 32'h10);
        tick();
        reset = 1; wb(4, 32'h99);
        tick();
        reset = 0; addrA = 4; useA = 1; addrB = 4; useB = 1;
        expect_now("post_reset4", M_ALL, 0, 0, 0, 0);
        tick();

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
